// File: rtl/therm_sng.sv
// Thermometer-code to stochastic bit-stream generator: captures one N-bit
// thermometer word and replays it as N serial beats in counter or bit-reversed order.
module therm_sng #(
    parameter int unsigned N    = 8,
    parameter int unsigned DIR  = 0,
    parameter int unsigned MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] therm_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         bit_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         in_err
);

    localparam int unsigned W = $clog2(N);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t       state;
    logic [W-1:0] idx;
    logic [W-1:0] sel;
    logic [N-1:0] tw;
    logic [N-1:0] tw_o;
    logic [N-1:0] fill;
    logic         legal;

    // Beat order: straight counter, or its bit-reverse to spread ones evenly.
    always_comb begin
        sel = idx;
        if (MODE != 0) begin
            for (int unsigned i = 0; i < W; i++) begin
                sel[i] = idx[W-1-i];
            end
        end
    end

    // Reorient the word so DIR=1 indexes from bit N-1 with the same select.
    always_comb begin
        tw_o = tw;
        if (DIR != 0) begin
            for (int unsigned i = 0; i < N; i++) begin
                tw_o[i] = tw[N-1-i];
            end
        end
    end

    // A legal code, once oriented to fill from bit 0, is 2^k-1: no carry chain gaps.
    always_comb begin
        fill  = (DIR != 0) ? ~therm_in : therm_in;
        legal = ((fill & (fill + N'(1))) == '0);
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RUN);
    assign out_last  = (state == RUN) && (idx == W'(N - 1));
    assign bit_out   = (state == RUN) && tw_o[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            tw     <= '0;
            in_err <= 1'b0;
        end else begin
            in_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        tw     <= therm_in;
                        idx    <= '0;
                        in_err <= ~legal;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (idx == W'(N - 1)) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_therm_sng.sv
// Bench for therm_sng: four N=8 instances covering every MODE/DIR pairing, driven in lockstep.
module tb_therm_sng;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] therm_in;
    logic         in_valid;
    logic         out_ready;
    logic [3:0]   in_ready;
    logic [3:0]   bit_out;
    logic [3:0]   out_valid;
    logic [3:0]   out_last;
    logic [3:0]   in_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance d: MODE = d[0], DIR = d[1].
    therm_sng #(.N(N), .DIR(0), .MODE(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .therm_in(therm_in), .in_valid(in_valid),
        .in_ready(in_ready[0]), .bit_out(bit_out[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_last(out_last[0]), .in_err(in_err[0]));
    therm_sng #(.N(N), .DIR(0), .MODE(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .therm_in(therm_in), .in_valid(in_valid),
        .in_ready(in_ready[1]), .bit_out(bit_out[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_last(out_last[1]), .in_err(in_err[1]));
    therm_sng #(.N(N), .DIR(1), .MODE(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .therm_in(therm_in), .in_valid(in_valid),
        .in_ready(in_ready[2]), .bit_out(bit_out[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready), .out_last(out_last[2]), .in_err(in_err[2]));
    therm_sng #(.N(N), .DIR(1), .MODE(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .therm_in(therm_in), .in_valid(in_valid),
        .in_ready(in_ready[3]), .bit_out(bit_out[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready), .out_last(out_last[3]), .in_err(in_err[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      w;
        logic [3:0][7:0] exp;   // exp[d][b] = bit_out of instance d on beat b
        logic [3:0]      err;
        logic [7:0]      stall; // one-cycle out_ready drop on each flagged beat
        bit              poke;  // keep in_valid asserted through the stream
    } vec_t;

    function automatic vec_t mk(input logic [7:0] w, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] err,
                                input logic [7:0] stall, input bit poke);
        vec_t v;
        v.w = w;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        v.err = err; v.stall = stall; v.poke = poke;
        return v;
    endfunction

    // Reference: beat b shows word bit at position r (r = b or b reversed), mirrored for DIR=1.
    function automatic logic [7:0] model_stream(input logic [7:0] w, input bit dir, input bit mode);
        logic [7:0] s;
        int r, p;
        for (int b = 0; b < 8; b++) begin
            r = mode ? (((b & 1) << 2) | (b & 2) | ((b >> 2) & 1)) : b;
            p = dir ? 7 - r : r;
            s[b] = w[p];
        end
        return s;
    endfunction

    function automatic logic [7:0] low_ones(input int k);
        int v;
        v = (1 << k) - 1;
        return v[7:0];
    endfunction

    function automatic bit model_legal(input logic [7:0] w, input bit dir);
        logic [7:0] code;
        for (int k = 0; k <= 8; k++) begin
            code = dir ? ~low_ones(8 - k) : low_ones(k);
            if (w == code) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Entered and left at posedge+1: offers w, then follows the stream to the idle cycle.
    task automatic run_stream(input logic [7:0] w, input logic [3:0][7:0] e, input logic [3:0] er,
                              input logic [7:0] stall, input bit rnd, input bit poke);
        int b, cyc;
        int ones [4];
        bit stalled, first;
        therm_in  = w;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("accept_ready", d, in_ready[d], 1);
            chk("accept_nvalid", d, out_valid[d], 0);
            ones[d] = 0;
        end
        @(posedge clk); #1;
        in_valid = poke;
        therm_in = 8'($urandom);
        b = 0; cyc = 0; first = 1'b1; stalled = 1'b0;
        while (b < 8 && cyc < 100) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            else     out_ready = !(stall[b] && !stalled);
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                chk("run_valid", d, out_valid[d], 1);
                chk("run_nready", d, in_ready[d], 0);
                chk("bit_out", d, bit_out[d], e[d][b]);
                chk("out_last", d, out_last[d], (b == 7));
                chk("in_err", d, in_err[d], first ? er[d] : 1'b0);
                if (out_ready) ones[d] += int'(bit_out[d]);
            end
            first = 1'b0;
            @(posedge clk); #1;
            if (out_ready) begin b++; stalled = 1'b0; end
            else stalled = 1'b1;
            cyc++;
        end
        if (cyc >= 100) chk("beat_timeout", 0, cyc, 0);
        in_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk("done_ready", d, in_ready[d], 1);
            chk("done_nvalid", d, out_valid[d], 0);
            chk("done_err", d, in_err[d], 0);
            chk("ones_count", d, ones[d], $countones(w));
        end
        @(posedge clk); #1;
    endtask

    vec_t            tbl [6];
    logic [7:0]      rw;
    logic [3:0][7:0] re;
    logic [3:0]      rerr;

    initial begin
        tbl[0] = mk(8'b00000111, 8'b00000111, 8'b00010101, 8'b11100000, 8'b10101000, 4'b1100, 8'h00, 0);
        tbl[1] = mk(8'b11100000, 8'b11100000, 8'b10101000, 8'b00000111, 8'b00010101, 4'b0011, 8'h00, 0);
        tbl[2] = mk(8'b00000000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 8'h00, 0);
        tbl[3] = mk(8'b11111111, 8'hff, 8'hff, 8'hff, 8'hff, 4'b0000, 8'h00, 0);
        tbl[4] = mk(8'b00011111, 8'b00011111, 8'b01010111, 8'b11111000, 8'b11101010, 4'b1100, 8'b00011100, 1);
        tbl[5] = mk(8'b00000101, 8'b00000101, 8'b00000101, 8'b10100000, 8'b10100000, 4'b1111, 8'h00, 0);

        therm_in = '0; in_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("rst_ready", d, in_ready[d], 1);
            chk("rst_valid", d, out_valid[d], 0);
            chk("rst_bit", d, bit_out[d], 0);
            chk("rst_last", d, out_last[d], 0);
            chk("rst_err", d, in_err[d], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++)
            run_stream(tbl[t].w, tbl[t].exp, tbl[t].err, tbl[t].stall, 1'b0, tbl[t].poke);

        // Abort a stream after four beats with an asynchronous reset.
        therm_in = 8'hff; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        for (int d = 0; d < 4; d++) chk("pre_abort_bit", d, bit_out[d], 1);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("abort_valid", d, out_valid[d], 0);
            chk("abort_bit", d, bit_out[d], 0);
            chk("abort_last", d, out_last[d], 0);
            chk("abort_ready", d, in_ready[d], 1);
        end
        @(negedge clk);
        for (int d = 0; d < 4; d++) chk("abort_hold", d, out_valid[d], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_stream(tbl[5].w, tbl[5].exp, tbl[5].err, 8'h00, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) != 0) begin
                int k;
                k  = $urandom_range(0, 8);
                rw = ($urandom_range(0, 1) != 0) ? ~low_ones(8 - k) : low_ones(k);
            end else begin
                rw = 8'($urandom);
            end
            for (int d = 0; d < 4; d++) begin
                re[d]   = model_stream(rw, d[1], d[0]);
                rerr[d] = !model_legal(rw, d[1]);
            end
            run_stream(rw, re, rerr, 8'h00, 1'b1, ($urandom_range(0, 1) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/therm_sng.md
THERM_SNG -- requirements
Module: therm_sng

Interface
- REQ-001: Parameter N, default 8; width of the thermometer word and stream length in beats; SHALL be a power of two, >= 4.
- REQ-002: Parameter DIR, default 0; code orientation. 0 means ones fill from bit 0 (00000111). 1 means ones fill from bit N-1 (11100000).
- REQ-003: Parameter MODE, default 0; beat index order. 0 is counter order. 1 is bit-reversed counter order (low-autocorrelation).
- REQ-004: clk  input  1  single clock; all state changes on its rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous, active-low.
- REQ-006: therm_in  input  N  thermometer-coded value k (count of ones, 0..N).
- REQ-007: in_valid  input  1  therm_in is valid this cycle.
- REQ-008: in_ready  output  1  block can accept a word this cycle.
- REQ-009: bit_out  output  1  current stochastic stream bit.
- REQ-010: out_valid  output  1  bit_out is valid.
- REQ-011: out_ready  input  1  consumer accepts bit_out this cycle.
- REQ-012: out_last  output  1  high with out_valid on beat N-1 of a stream.
- REQ-013: in_err  output  1  one-cycle pulse: the accepted word was not a legal thermometer code for DIR.

Function
- REQ-014: Two states SHALL exist: IDLE and RUN, with a beat index idx of log2(N) bits and a word register tw of N bits.
- REQ-015: In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in RUN, in_ready SHALL be 0 and out_valid SHALL be 1.
- REQ-016: On in_valid && in_ready, the block SHALL load tw <= therm_in, set idx <= 0, and enter RUN on that edge; out_valid SHALL be high from the next cycle.
- REQ-017: sel SHALL be idx when MODE=0, and the bit-reverse of idx when MODE=1.
- REQ-018: When DIR=0, bit_out SHALL equal tw[sel]. When DIR=1, bit_out SHALL equal tw[N-1-sel].
- REQ-019: bit_out SHALL be driven only from registered state (tw, idx), with no path from therm_in.
- REQ-020: On out_valid && out_ready with idx < N-1, idx SHALL increment by 1.
- REQ-021: On out_valid && out_ready with idx == N-1, the block SHALL return to IDLE; idx SHALL wrap to 0.
- REQ-022: out_last SHALL equal (state==RUN && idx==N-1).
- REQ-023: While out_ready=0 in RUN, idx, tw, bit_out and out_last SHALL hold.
- REQ-024: in_valid during RUN SHALL be ignored; no word is captured.
- REQ-025: Each stream SHALL emit exactly N beats with exactly k ones, for any legal code including k=0 and k=N.
- REQ-026: A code is legal when DIR=0 and tw is of the form 0..01..1, or when DIR=1 and tw is of the form 1..10..0; all-zeros and all-ones are legal for both.
- REQ-027: An illegal word SHALL still be accepted and streamed per REQ-018, and in_err SHALL pulse for exactly the cycle after acceptance.
- REQ-028: Throughput SHALL be one word per N+1 cycles at best, because in_ready returns in the cycle after the last beat handshake.

Reset
- REQ-029: When rst_n=0, the block SHALL immediately go to IDLE with idx=0, tw=0, out_valid=0, bit_out=0, out_last=0 and in_err=0.
- REQ-030: While rst_n=0, in_ready SHALL be 1.
- REQ-031: On rst_n deassertion, the first accept SHALL be possible at the next rising edge.
- REQ-032: Reset in the middle of a stream SHALL discard the stream with no further beats.

Verification (N=8)
- REQ-033: MODE=0, DIR=0, therm_in=00000111, out_ready=1 -> bit_out over beats 0..7 = 1,1,1,0,0,0,0,0; out_last on beat 7; in_ready back high the cycle after beat 7.
- REQ-034: MODE=1, DIR=0, therm_in=00000111 -> sel order 0,4,2,6,1,5,3,7; bits 1,0,1,0,1,0,0,0 (three ones).
- REQ-035: MODE=0, DIR=1, therm_in=11100000 -> bits 1,1,1,0,0,0,0,0. Then therm_in=00000000 gives eight 0s, and therm_in=11111111 gives eight 1s, each with out_last on beat 7.
- REQ-036: MODE=0, DIR=0, therm_in=00011111, out_ready low on beats 2..4 for three cycles -> bit_out and idx frozen while low; total beats = 8; five ones; a second in_valid during RUN is not captured.
- REQ-037: DIR=0, therm_in=00000101 -> in_err pulses one cycle after accept; MODE=0 stream = 1,0,1,0,0,0,0,0.
- REQ-038: Pull rst_n low after beat 3 of a stream -> out_valid=0 and bit_out=0 asynchronously; after release, in_ready=1, and a new word streams from beat 0.
